// File: rtl/rom_download_writer.sv
// Buffers the SPI file-download word stream in a small FIFO and writes it to SDRAM over req/ack.
// Optional ROM_DL_CHECKSUM_EN adds a running 16-bit sum of committed words.
module rom_download_writer #(
    parameter int unsigned FIFO_AW    = 2,
    parameter int unsigned ADDR_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  dl_active,
    input  logic                  wr_toggle,
    input  logic [15:0]           wr_data,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data,
    input  logic                  mem_ack,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  overflow,
`ifdef ROM_DL_CHECKSUM_EN
    output logic [15:0]           checksum,
`endif
    output logic [ADDR_WIDTH-1:0] word_count
);

    localparam int unsigned DEPTH   = 2 ** FIFO_AW;
    localparam int unsigned ENTRY_W = ADDR_WIDTH + 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q;
    logic                  tog_q;
    logic                  dl_q;
    logic [FIFO_AW-1:0]    wr_ptr_q;
    logic [FIFO_AW-1:0]    rd_ptr_q;
    logic [FIFO_AW:0]      cnt_q;
    logic                  mem_req_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [15:0]           mem_data_q;
    logic                  cpu_hold_q;
    logic                  done_q;
    logic                  overflow_q;
    logic [ADDR_WIDTH-1:0] word_count_q;
`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0]           checksum_q;
`endif

    logic [ENTRY_W-1:0]    fifo_mem [DEPTH];
    logic [ENTRY_W-1:0]    head;
    logic                  push_ev;
    logic                  full;
    logic                  pop;
    logic                  push_ok;
    logic                  push_drop;
    logic                  dl_rise;

    assign push_ev   = wr_toggle ^ tog_q;
    assign full      = (cnt_q == (FIFO_AW + 1)'(DEPTH));
    assign pop       = mem_req_q & mem_ack;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok   = push_ev & (state_q == S_LOAD) & (~full | pop);
    assign push_drop = push_ev & (state_q == S_LOAD) & full & ~pop;
    assign dl_rise   = dl_active & ~dl_q;
    assign head      = fifo_mem[rd_ptr_q];

    // Storage array: the head word is already latched into mem_addr/mem_data while requested.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= {wr_addr, wr_data};
        end
    end

    // Control FSM, FIFO pointers and memory-side handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            tog_q        <= wr_toggle;
            dl_q         <= dl_active;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
`ifdef ROM_DL_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            tog_q  <= wr_toggle;
            dl_q   <= dl_active;
            done_q <= 1'b0;

            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + (FIFO_AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (FIFO_AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase

            // Request drops for a cycle after every ack, giving the 2-cycle minimum per word.
            if (pop) begin
                mem_req_q <= 1'b0;
            end else if (!mem_req_q && (cnt_q != '0)) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= head[ENTRY_W-1:16];
                mem_data_q <= head[15:0];
            end

            if (push_ok && (word_count_q != '1)) begin
                word_count_q <= word_count_q + ADDR_WIDTH'(1);
            end
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
`ifdef ROM_DL_CHECKSUM_EN
            if (pop) begin
                checksum_q <= checksum_q + mem_data_q;
            end
`endif

            case (state_q)
                S_IDLE: begin
                    if (dl_rise) begin
                        state_q      <= S_LOAD;
                        word_count_q <= '0;
                        overflow_q   <= 1'b0;
                        cpu_hold_q   <= 1'b1;
`ifdef ROM_DL_CHECKSUM_EN
                        checksum_q   <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (!dl_active) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((cnt_q == '0) && !mem_req_q) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;
`ifdef ROM_DL_CHECKSUM_EN
    assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_rom_download_writer.sv
// Directed self-checking bench for rom_download_writer (default FIFO depth 4).
module tb_rom_download_writer;

    localparam int unsigned AW = 23;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          dl_active;
    logic          wr_toggle;
    logic [15:0]   wr_data;
    logic [AW-1:0] wr_addr;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_ack;
    logic          cpu_hold;
    logic          done;
    logic          overflow;
    logic [AW-1:0] word_count;
`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    int checks = 0;
    int errors = 0;

    rom_download_writer #(.FIFO_AW(2), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .wr_toggle  (wr_toggle),
        .wr_data    (wr_data),
        .wr_addr    (wr_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ack    (mem_ack),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .overflow   (overflow),
`ifdef ROM_DL_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [15:0] d);
        wr_addr   = a;
        wr_data   = d;
        wr_toggle = ~wr_toggle;
        tick();
    endtask

    // Wait for a request, check its payload, then ack it for one cycle.
    task automatic service(input string tag, input logic [AW-1:0] a, input logic [15:0] d);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(mem_req), 32'd1);
        check({tag, "_addr"}, 32'(mem_addr), 32'(a));
        check({tag, "_data"}, 32'(mem_data), 32'(d));
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check({tag, "_reqlow"}, 32'(mem_req), 32'd0);
    endtask

    // Drop dl_active and watch the end of the download: one done pulse, no stray writes.
    task automatic finish_dl(input string tag);
        int dones = 0;
        int reqs  = 0;
        dl_active = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) dones++;
            if (mem_req) reqs++;
        end
        check({tag, "_done_pulses"}, 32'(dones), 32'd1);
        check({tag, "_extra_reqs"}, 32'(reqs), 32'd0);
        check({tag, "_hold_clear"}, 32'(cpu_hold), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        dl_active = 1'b0;
        wr_toggle = 1'b1;
        wr_data   = '0;
        wr_addr   = '0;
        mem_ack   = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(mem_data), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_wc", 32'(word_count), 32'd0);
`ifdef ROM_DL_CHECKSUM_EN
        check("rst_cs", 32'(checksum), 32'd0);
`endif

        // Toggle in IDLE is ignored.
        push(23'h000123, 16'hBEEF);
        repeat (4) tick();
        check("idle_req", 32'(mem_req), 32'd0);
        check("idle_wc", 32'(word_count), 32'd0);

        // Download A: three words written in order.
        dl_active = 1'b1;
        tick();
        check("a_hold_set", 32'(cpu_hold), 32'd1);
        push(23'h700000, 16'h1111);
        push(23'h700001, 16'h2222);
        push(23'h700002, 16'h3333);
        check("a_wc", 32'(word_count), 32'd3);
        service("a0", 23'h700000, 16'h1111);
        service("a1", 23'h700001, 16'h2222);
        service("a2", 23'h700002, 16'h3333);
        finish_dl("a");
        check("a_wc_final", 32'(word_count), 32'd3);
`ifdef ROM_DL_CHECKSUM_EN
        check("a_cs", 32'(checksum), 32'h6666);
`endif

        // Download B: fill FIFO, push together with ack, then toggle during DRAIN.
        dl_active = 1'b1;
        tick();
        check("b_wc_clr", 32'(word_count), 32'd0);
        push(23'h000200, 16'hB000);
        push(23'h000201, 16'hB001);
        push(23'h000202, 16'hB002);
        push(23'h000203, 16'hB003);
        check("b_full_wc", 32'(word_count), 32'd4);
        check("b_full_ovf", 32'(overflow), 32'd0);
        check("b_head_req", 32'(mem_req), 32'd1);
        check("b_head_addr", 32'(mem_addr), 32'h200);
        mem_ack = 1'b1;
        push(23'h000204, 16'hB004);
        mem_ack = 1'b0;
        check("b_simul_wc", 32'(word_count), 32'd5);
        check("b_simul_ovf", 32'(overflow), 32'd0);
        dl_active = 1'b0;
        tick();
        push(23'h0002FF, 16'hDEAD);
        service("b1", 23'h000201, 16'hB001);
        service("b2", 23'h000202, 16'hB002);
        service("b3", 23'h000203, 16'hB003);
        service("b4", 23'h000204, 16'hB004);
        finish_dl("b");
        check("b_wc_final", 32'(word_count), 32'd5);
`ifdef ROM_DL_CHECKSUM_EN
        check("b_cs", 32'(checksum), 32'h700A);
`endif

        // Download C: six words with acks held off; last two dropped.
        dl_active = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            push(AW'(32'h300 + i), 16'(32'hC000 + i));
        end
        check("c_ovf", 32'(overflow), 32'd1);
        check("c_wc", 32'(word_count), 32'd4);
        service("c0", 23'h000300, 16'hC000);
        service("c1", 23'h000301, 16'hC001);
        service("c2", 23'h000302, 16'hC002);
        service("c3", 23'h000303, 16'hC003);
        finish_dl("c");
        check("c_ovf_sticky", 32'(overflow), 32'd1);
`ifdef ROM_DL_CHECKSUM_EN
        check("c_cs", 32'(checksum), 32'h0006);
`endif

        // Download D: reset while a request is outstanding, then restart.
        dl_active = 1'b1;
        tick();
        push(23'h000400, 16'hD000);
        tick();
        check("d_req_out", 32'(mem_req), 32'd1);
        reset_n   = 1'b0;
        dl_active = 1'b0;
        tick();
        check("d_rst_req", 32'(mem_req), 32'd0);
        check("d_rst_hold", 32'(cpu_hold), 32'd0);
        check("d_rst_wc", 32'(word_count), 32'd0);
        reset_n = 1'b1;
        repeat (4) tick();
        check("d_fifo_empty", 32'(mem_req), 32'd0);
        dl_active = 1'b1;
        tick();
        check("e_hold", 32'(cpu_hold), 32'd1);
        push(23'h000500, 16'hE000);
        service("e0", 23'h000500, 16'hE000);
        finish_dl("e");
        check("e_wc", 32'(word_count), 32'd1);
        check("e_ovf", 32'(overflow), 32'd0);
`ifdef ROM_DL_CHECKSUM_EN
        check("e_cs", 32'(checksum), 32'hE000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
